// File: rtl/conv_pkg.sv
// Shared types and index-bound helper for the convolution index generator.
// The bound function is used by the RTL and by the bench scoreboard.
package conv_pkg;

   localparam int DEFAULT_ADDR_WIDTH = 5;

   typedef enum logic [1:0] {IDLE, RUN, DONE} conv_state_t;

   typedef struct packed {
      int lo;
      int hi;
   } conv_bounds_t;

   // k range for output n: k_lo = max(0, n-Lh+1), k_hi = min(n, Lx-1)
   function automatic conv_bounds_t calc_bounds(input int n, input int len_x, input int len_h);
      conv_bounds_t b;
      b.lo = (n >= len_h) ? n - len_h + 1 : 0;
      b.hi = (n < len_x - 1) ? n : len_x - 1;
      return b;
   endfunction

endpackage

// File: rtl/conv_index_gen_if.sv
// Index-tuple handshake between the generator (master) and the MAC datapath (slave).
interface conv_index_gen_if
   import conv_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int N_WIDTH    = ADDR_WIDTH + 1
);

   logic                  addr_valid;
   logic                  addr_ready;
   logic [ADDR_WIDTH-1:0] addr_x;
   logic [ADDR_WIDTH-1:0] addr_h;
   logic [N_WIDTH-1:0]    idx_n;
   logic                  first_k;
   logic                  last_k;

   modport master (
      output addr_valid, addr_x, addr_h, idx_n, first_k, last_k,
      input  addr_ready
   );

   modport slave (
      input  addr_valid, addr_x, addr_h, idx_n, first_k, last_k,
      output addr_ready
   );

endinterface

// File: rtl/conv_bound_calc.sv
// Combinational k_lo/k_hi for a given output index n and the latched lengths.
module conv_bound_calc
   import conv_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int N_WIDTH    = ADDR_WIDTH + 1
) (
   input  logic [N_WIDTH:0]      n,
   input  logic [ADDR_WIDTH:0]   len_x,
   input  logic [ADDR_WIDTH:0]   len_h,
   output logic [ADDR_WIDTH-1:0] k_lo,
   output logic [ADDR_WIDTH-1:0] k_hi
);

   conv_bounds_t bounds;

   always_comb begin
      bounds = calc_bounds(int'(n), int'(len_x), int'(len_h));
      k_lo   = ADDR_WIDTH'(bounds.lo);
      k_hi   = ADDR_WIDTH'(bounds.hi);
   end

endmodule

// File: rtl/conv_index_gen.sv
// Walks the nested (n, k) index space of a 1-D linear convolution and hands
// each tuple to the MAC datapath through a valid/ready handshake.
module conv_index_gen
   import conv_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int N_WIDTH    = ADDR_WIDTH + 1
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                start,
   input  logic                clr,
   input  logic [ADDR_WIDTH:0] len_x,
   input  logic [ADDR_WIDTH:0] len_h,
   conv_index_gen_if.master    bus,
   output logic                busy,
   output logic                done
);

   localparam int CW = N_WIDTH + 1;

   conv_state_t           state_q, state_d;
   logic [N_WIDTH-1:0]    n_q, n_d;
   logic [ADDR_WIDTH-1:0] k_q, k_d;
   logic [ADDR_WIDTH:0]   lx_q, lx_d, lh_q, lh_d;

   logic [CW-1:0]         n_ext, n_nxt, n_last;
   logic [ADDR_WIDTH-1:0] cur_lo, cur_hi, nxt_lo, nxt_hi;
   logic                  run;

   assign n_ext  = CW'(n_q);
   assign n_nxt  = n_ext + CW'(1);
   assign n_last = CW'(lx_q) + CW'(lh_q) - CW'(2);
   assign run    = (state_q == RUN);

   conv_bound_calc #(.ADDR_WIDTH(ADDR_WIDTH), .N_WIDTH(N_WIDTH)) u_cur_bounds (
      .n     (n_ext),
      .len_x (lx_q),
      .len_h (lh_q),
      .k_lo  (cur_lo),
      .k_hi  (cur_hi)
   );

   // nxt_hi is unused: the next n always starts at its low bound
   conv_bound_calc #(.ADDR_WIDTH(ADDR_WIDTH), .N_WIDTH(N_WIDTH)) u_nxt_bounds (
      .n     (n_nxt),
      .len_x (lx_q),
      .len_h (lh_q),
      .k_lo  (nxt_lo),
      .k_hi  (nxt_hi)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         n_q     <= '0;
         k_q     <= '0;
         lx_q    <= '0;
         lh_q    <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         k_q     <= k_d;
         lx_q    <= lx_d;
         lh_q    <= lh_d;
      end
   end

   // Indices advance only on an accepted tuple; clr overrides everything
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      k_d     = k_q;
      lx_d    = lx_q;
      lh_d    = lh_q;
      if (clr) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (len_x == '0 || len_h == '0) begin
                     state_d = DONE;
                  end else begin
                     state_d = RUN;
                     lx_d    = len_x;
                     lh_d    = len_h;
                     n_d     = '0;
                     k_d     = '0;
                  end
               end
            end
            RUN: begin
               if (bus.addr_ready) begin
                  if (k_q != cur_hi) begin
                     k_d = k_q + ADDR_WIDTH'(1);
                  end else if (n_ext < n_last) begin
                     n_d = n_q + N_WIDTH'(1);
                     k_d = nxt_lo;
                  end else begin
                     state_d = DONE;
                  end
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.addr_valid = run;
   assign bus.addr_x     = run ? k_q : '0;
   assign bus.addr_h     = run ? ADDR_WIDTH'(n_ext - CW'(k_q)) : '0;
   assign bus.idx_n      = run ? n_q : '0;
   assign bus.first_k    = run && (k_q == cur_lo);
   assign bus.last_k     = run && (k_q == cur_hi);
   assign busy           = run;
   assign done           = (state_q == DONE);

endmodule

// File: tb/tb_conv_index_gen.sv
// Scoreboard bench for conv_index_gen: expected tuples are queued at start
// and popped as the DUT transfers them.
module tb_conv_index_gen;
   import conv_pkg::*;

   localparam int AW = 5;
   localparam int NW = AW + 1;

   typedef struct {
      int n;
      int k;
      int h;
      int first;
      int last;
   } tuple_t;

   logic          clk = 1'b0;
   logic          rstn;
   logic          start;
   logic          clr;
   logic [AW:0]   len_x;
   logic [AW:0]   len_h;
   logic          busy;
   logic          done;

   conv_index_gen_if #(.ADDR_WIDTH(AW), .N_WIDTH(NW)) bus ();

   conv_index_gen #(.ADDR_WIDTH(AW), .N_WIDTH(NW)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .start (start),
      .clr   (clr),
      .len_x (len_x),
      .len_h (len_h),
      .bus   (bus),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;
   int cycle        = 0;
   int xfers, done_cnt, first_xfer_cycle, last_xfer_cycle, done_cycle, start_cycle;
   int last_obs_n, last_obs_k, last_obs_h;
   bit stall_seen   = 1'b0;
   tuple_t held;
   tuple_t expq[$];

   // Hand-derived sequence for Lx=3, Lh=2
   int tab_n[6]     = '{0, 1, 1, 2, 2, 3};
   int tab_k[6]     = '{0, 0, 1, 1, 2, 2};
   int tab_h[6]     = '{0, 1, 0, 1, 0, 1};
   int tab_first[6] = '{1, 1, 0, 1, 0, 1};
   int tab_last[6]  = '{1, 0, 1, 0, 1, 1};

   task automatic checkOutput(input string tag, input int actual, input int expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   function automatic tuple_t sampleBus();
      tuple_t t;
      t.n     = int'(bus.idx_n);
      t.k     = int'(bus.addr_x);
      t.h     = int'(bus.addr_h);
      t.first = int'(bus.first_k);
      t.last  = int'(bus.last_k);
      return t;
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         cycle++;
      end
   end

   // Monitor: pops the scoreboard on every transfer and checks stall stability
   initial begin
      tuple_t cur;
      tuple_t e;
      forever begin
         @(negedge clk);
         if (rstn) begin
            cur = sampleBus();
            if (stall_seen) begin
               checkOutput("stall_valid", int'(bus.addr_valid), 1);
               checkOutput("stall_n", cur.n, held.n);
               checkOutput("stall_k", cur.k, held.k);
               checkOutput("stall_first", cur.first, held.first);
               checkOutput("stall_last", cur.last, held.last);
            end
            if (bus.addr_valid && bus.addr_ready) begin
               if (expq.size() == 0) begin
                  checkOutput("extra_tuple", 1, 0);
               end else begin
                  e = expq.pop_front();
                  checkOutput("tup_n", cur.n, e.n);
                  checkOutput("tup_x", cur.k, e.k);
                  checkOutput("tup_h", cur.h, e.h);
                  checkOutput("tup_first", cur.first, e.first);
                  checkOutput("tup_last", cur.last, e.last);
               end
               if (xfers == 0) first_xfer_cycle = cycle;
               last_xfer_cycle = cycle;
               last_obs_n = cur.n;
               last_obs_k = cur.k;
               last_obs_h = cur.h;
               xfers++;
            end
            stall_seen = bus.addr_valid && !bus.addr_ready;
            held       = cur;
            if (done) begin
               done_cnt++;
               done_cycle = cycle;
            end
         end else begin
            stall_seen = 1'b0;
         end
      end
   end

   task automatic pushExpected(input int lx, input int lh);
      conv_bounds_t b;
      tuple_t t;
      if (lx == 3 && lh == 2) begin
         for (int i = 0; i < 6; i++) begin
            t.n = tab_n[i]; t.k = tab_k[i]; t.h = tab_h[i];
            t.first = tab_first[i]; t.last = tab_last[i];
            expq.push_back(t);
         end
      end else if (lx > 0 && lh > 0) begin
         for (int n = 0; n <= lx + lh - 2; n++) begin
            b = calc_bounds(n, lx, lh);
            for (int k = b.lo; k <= b.hi; k++) begin
               t.n = n; t.k = k; t.h = n - k;
               t.first = (k == b.lo) ? 1 : 0;
               t.last  = (k == b.hi) ? 1 : 0;
               expq.push_back(t);
            end
         end
      end
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_valid"}, int'(bus.addr_valid), 0);
      checkOutput({tag, "_busy"}, int'(busy), 0);
      checkOutput({tag, "_done"}, int'(done), 0);
      checkOutput({tag, "_x"}, int'(bus.addr_x), 0);
      checkOutput({tag, "_n"}, int'(bus.idx_n), 0);
      checkOutput({tag, "_first"}, int'(bus.first_k), 0);
      checkOutput({tag, "_last"}, int'(bus.last_k), 0);
   endtask

   // mode: 0 = ready held high, 1 = ready toggles 1,0; abort_kind: 1 = clr+start, 2 = async reset
   task automatic applyStimulus(input int lx, input int lh, input int mode, input int inj_at,
                                input int abort_kind, input int abort_at, input int exp_span);
      int i;
      int budget;
      bit aborted;
      assert (lx <= 2**AW && lh <= 2**AW) else $error("[TB] illegal length %0d/%0d", lx, lh);
      expq.delete();
      xfers    = 0;
      done_cnt = 0;
      pushExpected(lx, lh);
      budget = 2 * lx * lh + 20;
      @(posedge clk); #1;
      start = 1'b1;
      len_x = (AW+1)'(lx);
      len_h = (AW+1)'(lh);
      @(posedge clk); #1;
      start       = 1'b0;
      start_cycle = cycle;
      aborted     = 1'b0;
      i           = 0;
      while (i < budget && done_cnt == 0 && !aborted) begin
         bus.addr_ready = (mode == 1) ? ((i % 2) == 0) : 1'b1;
         if (i == inj_at) begin
            start = 1'b1; len_x = 1; len_h = 1;
         end
         if (i == abort_at && abort_kind == 1) begin
            clr = 1'b1; start = 1'b1;
         end
         if (i == abort_at && abort_kind == 2) begin
            #2 rstn = 1'b0;
            #1 checkIdle("rst_mid");
            aborted = 1'b1;
         end
         @(posedge clk); #1;
         start = 1'b0;
         clr   = 1'b0;
         len_x = (AW+1)'(lx);
         len_h = (AW+1)'(lh);
         if (i == abort_at && abort_kind == 1) aborted = 1'b1;
         i++;
      end
      if (abort_kind == 1) begin
         checkIdle("clr_next");
         repeat (4) @(posedge clk);
         #1;
         checkOutput("clr_no_done", done_cnt, 0);
         checkOutput("clr_xfers", xfers, abort_at + 1);
         expq.delete();
      end else if (abort_kind == 2) begin
         checkIdle("rst_hold");
         @(negedge clk);
         rstn = 1'b1;
         @(posedge clk); #1;
         checkIdle("rst_release");
         expq.delete();
      end else begin
         checkOutput("done_seen", done_cnt, 1);
         repeat (3) @(posedge clk);
         #1;
         checkOutput("done_pulses", done_cnt, 1);
         checkOutput("tuple_count", xfers, lx * lh);
         checkOutput("sb_left", expq.size(), 0);
         checkIdle("post_run");
         if (lx == 0 || lh == 0) begin
            checkOutput("zero_done_lat", done_cycle - start_cycle, 0);
         end else begin
            checkOutput("first_lat", first_xfer_cycle - start_cycle, 0);
            checkOutput("xfer_span", last_xfer_cycle - first_xfer_cycle, exp_span);
            checkOutput("done_lat", done_cycle - last_xfer_cycle, 1);
            checkOutput("final_n", last_obs_n, lx + lh - 2);
            checkOutput("final_k", last_obs_k, lx - 1);
            checkOutput("final_h", last_obs_h, lh - 1);
         end
      end
   endtask

   initial begin
      rstn           = 1'b0;
      start          = 1'b0;
      clr            = 1'b0;
      len_x          = '0;
      len_h          = '0;
      bus.addr_ready = 1'b0;
      #12;
      checkIdle("reset");
      @(negedge clk);
      rstn = 1'b1;

      applyStimulus(3, 2, 0, -1, 0, -1, 5);
      applyStimulus(3, 2, 1, -1, 0, -1, 10);
      applyStimulus(1, 1, 0, -1, 0, -1, 0);
      applyStimulus(0, 4, 0, -1, 0, -1, 0);
      applyStimulus(32, 32, 0, -1, 0, -1, 1023);
      applyStimulus(3, 2, 1, 3, 0, -1, 10);
      applyStimulus(3, 2, 0, -1, 1, 2, 0);
      applyStimulus(3, 2, 0, -1, 0, -1, 5);
      applyStimulus(4, 3, 0, -1, 2, 4, 0);
      applyStimulus(2, 3, 0, -1, 0, -1, 5);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
